// File: rtl/inst_loader.sv
// rtl/inst_loader.sv - byte-stream loader that assembles 32-bit words and writes them to instruction memory
module inst_loader #(
  parameter int DEPTH   = 128,
  parameter int TIMEOUT = 1024,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    load_len,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  output logic          IWEN,
  output logic [AW-1:0] I_Addr,
  output logic [31:0]   wInst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ERR} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] eff_len;
  logic [AW-1:0] word_cnt;
  logic [AW-1:0] word_cnt_nxt;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] idle_cnt;
  logic [23:0]   shift_q;
  logic          drain_q;
  logic          accept;
  logic          last_byte;
  logic          last_word;
  logic          timeout_hit;

  assign eff_len      = ((load_len == 8'd0) || (32'(load_len) > DEPTH)) ? LW'(DEPTH) : LW'(load_len);
  assign accept       = (state == LOAD) && byte_valid;
  assign last_byte    = (byte_cnt == 2'd3);
  assign last_word    = ((LW'(word_cnt) + LW'(1)) == len_q);
  assign timeout_hit  = (state == LOAD) && !accept && (idle_cnt == TW'(TIMEOUT - 1));
  assign word_cnt_nxt = (word_cnt == AW'(DEPTH - 1)) ? '0 : word_cnt + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A byte that completes the final word wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD: begin
        if (accept && last_byte && last_word) begin
          state_nxt = DRAIN;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      DRAIN:   if (drain_q) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == LOAD);
    IWEN       = (state == LOAD) || (state == DRAIN);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
      shift_q  <= '0;
      drain_q  <= 1'b0;
      I_Addr   <= '0;
      wInst    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= eff_len;
            word_cnt <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            shift_q  <= '0;
            drain_q  <= 1'b0;
            I_Addr   <= '0;
            wInst    <= '0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          drain_q <= 1'b0;
          if (accept) begin
            idle_cnt <= '0;
            byte_cnt <= byte_cnt + 2'd1;
            shift_q  <= {shift_q[15:0], byte_data};
            // Memory writes every cycle, so wInst only ever changes to a whole word.
            if (last_byte) begin
              wInst    <= {shift_q, byte_data};
              I_Addr   <= word_cnt;
              word_cnt <= word_cnt_nxt;
            end
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
            if (timeout_hit) err <= 1'b1;
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// tb/tb_inst_loader.sv - self-checking bench for inst_loader with a word scoreboard and memory model
module tb_inst_loader;

  localparam int DEPTH   = 128;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        IWEN;
  logic [6:0]  I_Addr;
  logic [31:0] wInst;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [DEPTH];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          drv_bcnt;
  int          drv_widx;
  logic [31:0] drv_word;

  inst_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .IWEN      (IWEN),
    .I_Addr    (I_Addr),
    .wInst     (wInst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Memory writes on every edge while IWEN is high; sampled half a cycle early.
  always @(negedge clk) begin
    if (IWEN) mem[I_Addr] <= wInst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
    drv_bcnt = 0;
    drv_widx = 0;
    drv_word = '0;
  endtask

  task automatic drive_byte(input logic [7:0] b, output int waits);
    logic got;
    logic last;
    exp_t e;
    byte_valid = 1'b1;
    byte_data  = b;
    last       = (drv_bcnt == 3);
    if (last) begin
      e.addr = 7'(drv_widx);
      e.data = {drv_word[23:0], b};
      exp_q.push_back(e);
      drv_widx++;
    end
    drv_word = {drv_word[23:0], b};
    drv_bcnt = (drv_bcnt + 1) % 4;
    waits = 0;
    got   = 1'b0;
    while (!got && waits < 16) begin
      @(negedge clk);
      got = byte_ready;
      tick();
      if (!got) waits++;
    end
    byte_valid = 1'b0;
    if (last && got) begin
      e = exp_q.pop_front();
      total_cnt++;
      if ({I_Addr, wInst} !== {e.addr, e.data})
        $display("FAIL word: got I_Addr=%0d wInst=%h, expected I_Addr=%0d wInst=%h", I_Addr, wInst, e.addr, e.data);
      else
        pass_cnt++;
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++;
    if ({IWEN, byte_ready, busy, done, err, I_Addr, wInst} !== '0)
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%b %0d %h, expected all zero", IWEN, byte_ready, busy, done, err, I_Addr, wInst);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    int w;
    int stalls = 0;
    do_start(8'd2);
    total_cnt++;
    if ({IWEN, busy, byte_ready, I_Addr, wInst} !== {3'b111, 7'd0, 32'd0})
      $display("FAIL basic_enter_load: got IWEN=%b busy=%b ready=%b I_Addr=%0d wInst=%h, expected 1 1 1 0 0", IWEN, busy, byte_ready, I_Addr, wInst);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      drive_byte(bytes[i], w);
      stalls += w;
    end
    total_cnt++;
    if (stalls !== 0) $display("FAIL basic_no_bubble: got %0d stall cycles, expected 0", stalls);
    else pass_cnt++;
    total_cnt++;
    if ({byte_ready, IWEN} !== 2'b01) $display("FAIL basic_drain1: got ready=%b IWEN=%b, expected 0 1", byte_ready, IWEN);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({IWEN, done, I_Addr, wInst} !== {2'b10, 7'd1, 32'h93001000})
      $display("FAIL basic_drain2: got IWEN=%b done=%b I_Addr=%0d wInst=%h, expected 1 0 1 93001000", IWEN, done, I_Addr, wInst);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({IWEN, done, busy} !== 3'b010) $display("FAIL basic_done: got IWEN=%b done=%b busy=%b, expected 0 1 0", IWEN, done, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: got done=%b, expected 0", done);
    else pass_cnt++;
    total_cnt++;
    if ({mem[0], mem[1]} !== {32'h13000000, 32'h93001000})
      $display("FAIL basic_mem: got %h %h, expected 13000000 93001000", mem[0], mem[1]);
    else pass_cnt++;
  endtask

  task automatic test_full_depth();
    logic [31:0] exp_mem [DEPTH];
    logic [7:0]  b;
    int w;
    int stalls = 0;
    int bad = 0;
    bit seen;
    do_start(8'd0);
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'($urandom_range(255));
        exp_mem[i] = {exp_mem[i][23:0], b};
        drive_byte(b, w);
        stalls += w;
      end
    end
    total_cnt++;
    if ({I_Addr, byte_ready, stalls} !== {7'd127, 1'b0, 32'd0})
      $display("FAIL full_last: got I_Addr=%0d ready=%b stalls=%0d, expected 127 0 0", I_Addr, byte_ready, stalls);
    else pass_cnt++;
    wait_done(seen);
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL full_done: got done_seen=%b, expected 1", seen);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) bad++;
    total_cnt++;
    if (bad !== 0) $display("FAIL full_mem: got %0d bad words (word0=%h), expected 0 (word0=%h)", bad, mem[0], exp_mem[0]);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int w;
    bit seen;
    do_start(8'd1);
    total_cnt++;
    if ({I_Addr, wInst} !== '0) $display("FAIL stall_cleared: got I_Addr=%0d wInst=%h, expected 0 0", I_Addr, wInst);
    else pass_cnt++;
    drive_byte(8'hA1, w);
    drive_byte(8'hB2, w);
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if ({IWEN, I_Addr, wInst} !== {1'b1, 7'd0, 32'd0})
        $display("FAIL stall_hold%0d: got IWEN=%b I_Addr=%0d wInst=%h, expected 1 0 0", i, IWEN, I_Addr, wInst);
      else pass_cnt++;
    end
    drive_byte(8'hC3, w);
    drive_byte(8'hD4, w);
    wait_done(seen);
    total_cnt++;
    if ({seen, mem[0]} !== {1'b1, 32'hA1B2C3D4}) $display("FAIL stall_done: got done=%b mem0=%h, expected 1 a1b2c3d4", seen, mem[0]);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int w;
    int n = 0;
    bit done_seen = 1'b0;
    do_start(8'd4);
    drive_byte(8'h11, w);
    drive_byte(8'h22, w);
    while (err !== 1'b1 && n < TIMEOUT + 16) begin
      tick();
      n++;
      if (done) done_seen = 1'b1;
    end
    total_cnt++;
    if (n !== TIMEOUT) $display("FAIL timeout_cycles: got %0d idle cycles, expected %0d", n, TIMEOUT);
    else pass_cnt++;
    total_cnt++;
    if ({IWEN, busy, err} !== 3'b011) $display("FAIL timeout_err_state: got IWEN=%b busy=%b err=%b, expected 0 1 1", IWEN, busy, err);
    else pass_cnt++;
    tick();
    if (done) done_seen = 1'b1;
    total_cnt++;
    if ({busy, err, done_seen, wInst, mem[0]} !== {3'b010, 32'd0, 32'd0})
      $display("FAIL timeout_idle: got busy=%b err=%b done=%b wInst=%h mem0=%h, expected 0 1 0 0 0", busy, err, done_seen, wInst, mem[0]);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int w;
    bit seen;
    do_start(8'd2);
    total_cnt++;
    if (err !== 1'b0) $display("FAIL start_clears_err: got err=%b, expected 0", err);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) drive_byte(8'(i), w);
    start    = 1'b1;
    load_len = 8'd1;
    drive_byte(8'h05, w);
    start    = 1'b0;
    total_cnt++;
    if ({busy, byte_ready, IWEN} !== 3'b111) $display("FAIL start_ignored_state: got busy=%b ready=%b IWEN=%b, expected 1 1 1", busy, byte_ready, IWEN);
    else pass_cnt++;
    for (int i = 6; i <= 8; i++) drive_byte(8'(i), w);
    wait_done(seen);
    total_cnt++;
    if ({seen, mem[0], mem[1]} !== {1'b1, 32'h01020304, 32'h05060708})
      $display("FAIL start_ignored_words: got done=%b %h %h, expected 1 01020304 05060708", seen, mem[0], mem[1]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int w;
    do_start(8'd2);
    for (int i = 1; i <= 5; i++) drive_byte(8'(i * 16), w);
    byte_valid = 1'b1;
    byte_data  = 8'h60;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    byte_valid = 1'b0;
    total_cnt++;
    if ({IWEN, byte_ready, busy, done, err, I_Addr, wInst} !== '0)
      $display("FAIL reset_mid_outputs: got %b/%b/%b/%b/%b %0d %h, expected all zero", IWEN, byte_ready, busy, done, err, I_Addr, wInst);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0) $display("FAIL reset_mid_queue: got %0d pending words, expected 0", exp_q.size());
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({busy, done, IWEN} !== 3'b000) $display("FAIL reset_mid_no_done: got busy=%b done=%b IWEN=%b, expected 0 0 0", busy, done, IWEN);
    else pass_cnt++;
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    total_cnt++;
    if ({busy, IWEN} !== 2'b00) $display("FAIL reset_over_start: got busy=%b IWEN=%b, expected 0 0", busy, IWEN);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_stall();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 128, which is the instruction-memory depth in 32-bit words (7-bit address).
REQ-002 SHALL have parameter TIMEOUT, default 1024, which is the maximum idle cycles allowed between bytes inside a session.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begins a load session when sampled high in IDLE.
REQ-006 SHALL have port load_len  input  8  word count, latched on start; 0 or a value above DEPTH means DEPTH.
REQ-007 SHALL have port byte_valid  input  1  upstream byte present.
REQ-008 SHALL have port byte_data  input  8  program byte, little-endian instruction order.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port IWEN  output  1  instruction-memory write session; holds the core PC at 0 while high.
REQ-011 SHALL have port I_Addr  output  7  instruction-memory word address.
REQ-012 SHALL have port wInst  output  32  instruction-memory write word.
REQ-013 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-015 SHALL have port err  output  1  sticky timeout flag, cleared by the next accepted start.

Function
REQ-016 SHALL implement the states IDLE, LOAD, DRAIN and ERR.
REQ-017 SHALL go from IDLE to LOAD on start=1: latch the effective length, clear the word and byte counters, clear err, and drive IWEN=1 from the next cycle.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL drive byte_ready=1 only in LOAD; a byte is accepted only when byte_valid and byte_ready are both high.
REQ-020 SHALL pack accepted bytes 0..3 of a word into the internal shift register lanes [31:24], [23:16], [15:8] and [7:0] respectively, which is the byte-lane order the core un-swaps.
REQ-021 SHALL, on the edge that accepts the 4th byte of word k, load wInst with the assembled word and I_Addr with k.
REQ-022 SHALL keep I_Addr and wInst stable otherwise; while IWEN=1 the memory writes every cycle, so partial words never appear on wInst.
REQ-023 SHALL keep I_Addr and wInst both at 0 until the first word completes.
REQ-024 SHALL increment the word counter modulo DEPTH; the word counter never exceeds the latched length.
REQ-025 SHALL, when the final word is accepted, drop byte_ready on the next cycle and enter DRAIN.
REQ-026 SHALL hold IWEN, I_Addr and wInst through exactly 2 DRAIN cycles so that the last word is written.
REQ-027 SHALL, at the end of DRAIN, go to IDLE with IWEN=0 and done=1 for that single cycle.
REQ-028 SHALL count idle cycles in LOAD, resetting the count on each accepted byte.
REQ-029 SHALL, when the idle count reaches TIMEOUT, go to ERR with IWEN=0 and err=1, discarding the partial word; words already written are kept.
REQ-030 SHALL return from ERR to IDLE on the next cycle, keeping err=1 until the next start.
REQ-031 SHALL give byte acceptance priority over timeout when both occur on the same edge.
REQ-032 SHALL sustain one byte per cycle with no bubble at word boundaries.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, force state IDLE, IWEN=0, byte_ready=0, busy=0, done=0, err=0, I_Addr=0, wInst=0, and all counters and the shift register to 0.
REQ-034 SHALL, on reset during LOAD or DRAIN, abort immediately with no done pulse; the core leaves its hold on the following cycle.
REQ-035 SHALL give reset priority over start.

Verification
REQ-036 SHALL be verified by: start, load_len=2, bytes 13 00 00 00 93 00 10 00 back-to-back -> wInst=0x13000000 with I_Addr=0, then 0x93001000 with I_Addr=1; IWEN high through 2 DRAIN cycles; done pulses once; memory words 0 and 1 match.
REQ-037 SHALL be verified by: start with load_len=0 and 512 bytes -> 128 words written, I_Addr reaches 127, no wrap overwrite, done=1.
REQ-038 SHALL be verified by: a 3-byte stall of byte_valid mid-word -> wInst unchanged during the stall; the completed word is still correct.
REQ-039 SHALL be verified by: 2 bytes followed by TIMEOUT idle cycles -> err=1, IWEN=0, no done; word 0 is unwritten; err clears on the next start.
REQ-040 SHALL be verified by: rst=1 asserted during byte 6 of an 8-byte session -> next cycle all outputs are 0 and state is IDLE; the core PC restarts at 0.
REQ-041 SHALL be verified by: start pulsed during LOAD -> ignored, with the word counter and the latched length unchanged.
